// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 FSM states, error codes and command bytes
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE, FAIL} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_XFER = 2'd2;
  localparam logic [1:0] ERR_NACK = 2'd3;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] RSP_ACK = 8'hFA;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 pins plus clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic clk_m, data_m, clk_q;
  // synchronizer chains reset high (idle bus) so reset release never fakes an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) {clk_m, clk_s, clk_q, data_m, data_s} <= '1;
    else {clk_m, clk_s, clk_q, data_m, data_s} <= {clk_in, clk_m, clk_s, data_in, data_m};
  assign fall = clk_q & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK/NACK and timeout reporting
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US = 120,
  parameter int START_TIMEOUT_MS = 15,
  parameter int XFER_TIMEOUT_MS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int INH_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int ST_CYC = CLK_FREQ_HZ / 1000 * START_TIMEOUT_MS;
  localparam int XF_CYC = CLK_FREQ_HZ / 1000 * XFER_TIMEOUT_MS;
  localparam int MAX_A = ST_CYC > XF_CYC ? ST_CYC : XF_CYC;
  localparam int MAX_CYC = MAX_A > INH_CYC ? MAX_A : INH_CYC;
  localparam int CNT_W = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] INH_L = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] ST_L = CNT_W'(ST_CYC - 1);
  localparam logic [CNT_W-1:0] XF_L = CNT_W'(XF_CYC - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic par, par_n, clk_oe_n, data_oe_n, done_n, err_n, ready_n;
  logic [1:0] err_code_n;
  logic clk_s, data_s, fall;
  ps2_line_sync u_sync (
    .clk(clk),
    .reset(reset),
    .clk_in(ps2_clk_in),
    .data_in(ps2_data_in),
    .clk_s(clk_s),
    .data_s(data_s),
    .fall(fall)
  );
  assign busy = state != IDLE;
  // next state and next registered outputs; timeouts are checked before edges so they win
  always_comb begin
    state_n = state;
    cnt_n = cnt - 1'b1;
    bitcnt_n = bitcnt;
    shreg_n = shreg;
    par_n = par;
    err_code_n = err_code;
    clk_oe_n = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    case (state)
      IDLE:
        if (tx_valid && tx_ready) begin
          state_n = INHIBIT;
          cnt_n = INH_L;
          shreg_n = tx_data;
          par_n = ~^tx_data;
          err_code_n = ERR_NONE;
          clk_oe_n = 1'b1;
          data_oe_n = 1'b0;
        end
      INHIBIT:
        if (cnt == '0) begin
          state_n = RTS;
          cnt_n = ST_L;
          clk_oe_n = 1'b0;
          data_oe_n = 1'b1;
        end else if (cnt == CNT_W'(1)) data_oe_n = 1'b1;
      RTS:
        if (cnt == '0) begin
          state_n = FAIL;
          err_code_n = ERR_START;
        end else if (fall) begin
          state_n = BITS;
          cnt_n = XF_L;
          bitcnt_n = 4'd1;
          data_oe_n = ~shreg[0];
        end
      BITS:
        if (cnt == '0) begin
          state_n = FAIL;
          err_code_n = ERR_XFER;
        end else if (fall) begin
          bitcnt_n = bitcnt + 4'd1;
          data_oe_n = bitcnt == 4'd8 ? ~par : bitcnt == 4'd9 ? 1'b0 : ~shreg[bitcnt[2:0]];
          state_n = bitcnt == 4'd9 ? ACK : BITS;
        end
      ACK:
        if (cnt == '0) begin
          state_n = FAIL;
          err_code_n = ERR_XFER;
        end else if (fall) begin
          state_n = data_s ? FAIL : WAIT_IDLE;
          err_code_n = data_s ? ERR_NACK : err_code;
        end
      WAIT_IDLE:
        if (cnt == '0) begin
          state_n = FAIL;
          err_code_n = ERR_XFER;
        end else if (clk_s && data_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == FAIL) begin
      clk_oe_n = 1'b0;
      data_oe_n = 1'b0;
    end
    done_n = state == WAIT_IDLE && state_n == IDLE;
    err_n = state_n == FAIL;
    ready_n = state_n == IDLE;
  end
  // state and output registers; async reset releases both lines immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      err_code <= ERR_NONE;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitcnt <= bitcnt_n;
      shreg <= shreg_n;
      par <= par_n;
      err_code <= err_code_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done <= done_n;
      err <= err_n;
      tx_ready <= ready_n;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed self-checking bench with a behavioural PS/2 device
`timescale 1ns/1ns
module tb_ps2_host_tx;
  import ps2_pkg::*;
  logic clk = 1'b0, reset = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic [1:0] err_code;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic [9:0] rx;
  bit dev_ok;
  longint t_fall, t_err;
  int tests = 0, fails = 0, n_done = 0, n_err = 0;

  ps2_host_tx #(.CLK_FREQ_HZ(1000000)) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  always @(negedge clk) begin
    n_done += int'(done);
    n_err += int'(err);
  end

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // device: waits for request-to-send, then 40-cycle bit clock; rx[i] sampled before each rising edge
  task automatic device(input int edges, input bit ack);
    rx = '0;
    dev_ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) break;
      @(negedge clk);
    end
    if (!(ps2_data_oe && !ps2_clk_oe)) return;
    dev_ok = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= edges; i++) begin
      dev_clk = 1'b0;
      if (i == 1) t_fall = $time;
      repeat (20) @(negedge clk);
      if (i <= 10) rx[i-1] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (10) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000000", {tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_clock: got %b expected 0", tx_ready);
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_clock: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_set_led;
    int hi = 0, rise = 0, d0 = n_done, e0 = n_err;
    start(CMD_SET_LED);
    for (int k = 1; k <= 300; k++) begin
      if (ps2_data_oe && rise == 0) rise = k;
      if (!ps2_clk_oe) break;
      hi++;
      @(negedge clk);
    end
    tests++;
    if (hi !== 120) begin
      fails++;
      $display("FAIL inhibit_len: got %0d expected 120", hi);
    end
    tests++;
    if (rise !== 120) begin
      fails++;
      $display("FAIL data_oe_rise: got %0d expected 120", rise);
    end
    device(11, 1'b1);
    repeat (50) @(negedge clk);
    tests++;
    if (!dev_ok || rx !== 10'b11_1110_1101) begin
      fails++;
      $display("FAIL led_bits: got %b expected 1111101101", rx);
    end
    tests++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      fails++;
      $display("FAIL led_done: got done=%0d err=%0d expected done=1 err=0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_enable;
    int d0 = n_done;
    start(CMD_ENABLE);
    device(11, 1'b1);
    repeat (50) @(negedge clk);
    tests++;
    if (!dev_ok || rx !== 10'b10_1111_0100) begin
      fails++;
      $display("FAIL enable_bits: got %b expected 1011110100", rx);
    end
    tests++;
    if (n_done - d0 !== 1 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL enable_done: got done=%0d ready=%b expected 1 1", n_done - d0, tx_ready);
    end
  endtask

  task automatic test_nack;
    int d0 = n_done, e0 = n_err;
    start(8'h00);
    device(11, 1'b0);
    repeat (50) @(negedge clk);
    tests++;
    if (!dev_ok || rx !== 10'b11_0000_0000) begin
      fails++;
      $display("FAIL nack_bits: got %b expected 1100000000", rx);
    end
    tests++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0 || err_code !== ERR_NACK) begin
      fails++;
      $display("FAIL nack_err: got err=%0d done=%0d code=%0d expected 1 0 3", n_err - e0, n_done - d0, err_code);
    end
    tests++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      fails++;
      $display("FAIL nack_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_start_timeout;
    int n = 0;
    start(8'hAA);
    for (int i = 0; i < 300; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) break;
      @(negedge clk);
    end
    while (!err && n < 16000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 15000 || err_code !== ERR_START) begin
      fails++;
      $display("FAIL start_timeout: got cycles=%0d code=%0d expected 15000 1", n, err_code);
    end
    tests++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      fails++;
      $display("FAIL start_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    end
  endtask

  // first fall reaches the FSM 3 cycles after the pin drops (2-FF sync + edge register)
  task automatic test_xfer_timeout;
    int d0;
    start(8'h3C);
    tests++;
    if (err_code !== ERR_NONE) begin
      fails++;
      $display("FAIL code_cleared: got %0d expected 0", err_code);
    end
    device(5, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (err) break;
      @(negedge clk);
    end
    t_err = $time;
    tests++;
    if (!err || (t_err - t_fall) / 10 != 2003 || err_code !== ERR_XFER) begin
      fails++;
      $display("FAIL xfer_timeout: got cycles=%0d code=%0d expected 2003 2", (t_err - t_fall) / 10, err_code);
    end
    d0 = n_done;
    start(CMD_RESET);
    device(11, 1'b1);
    repeat (50) @(negedge clk);
    tests++;
    if (!dev_ok || rx !== 10'b11_1111_1111 || n_done - d0 !== 1) begin
      fails++;
      $display("FAIL after_timeout: got bits=%b done=%0d expected 1111111111 1", rx, n_done - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = n_done, e0 = n_err;
    start(CMD_SET_LED);
    device(2, 1'b1);
    tests++;
    if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_bits: got data_oe=%b busy=%b expected 1 1", ps2_data_oe, busy);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || n_done - d0 !== 0 || n_err - e0 !== 0) begin
      fails++;
      $display("FAIL reset_recover: got ready=%b done=%0d err=%0d expected 1 0 0", tx_ready, n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_busy_ignore;
    int d0 = n_done, extra = 0;
    start(CMD_ENABLE);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_flags: got ready=%b busy=%b expected 0 1", tx_ready, busy);
    end
    tx_valid = 1'b0;
    device(11, 1'b1);
    for (int i = 0; i < 300; i++) begin
      extra += int'(ps2_clk_oe);
      @(negedge clk);
    end
    tests++;
    if (!dev_ok || rx !== 10'b10_1111_0100 || n_done - d0 !== 1 || extra !== 0) begin
      fails++;
      $display("FAIL busy_ignore: got bits=%b done=%0d extra=%0d expected 1011110100 1 0", rx, n_done - d0, extra);
    end
  endtask

  initial begin
    test_reset;
    test_set_led;
    test_enable;
    test_nack;
    test_start_timeout;
    test_xfer_timeout;
    test_reset_mid;
    test_busy_ignore;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
